// File: rtl/tile_map_writer.sv
// tile_map_writer
//   Owns the COLS x ROWS playfield tile map of CODE_W-bit shade codes and is
//   the only agent that writes it. Commands (cell write, row fill, full clear,
//   row drop) arrive over a valid/ready interface; a registered read port
//   serves the background renderer independently of command activity.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both 1. cmd_ready depends on state only (high in IDLE) and
//   never on cmd_valid; operands are captured on the accepting edge and
//   inputs are ignored while busy.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_op              0=WRITE 1=FILL_ROW 2=CLEAR_ALL 3=ROW_DROP
//   cmd_col/row/code    command operands
//   rd_col/rd_row       renderer read address
//   rd_code             registered cell code (1-cycle latency, 0 if out of range)
//   busy                multi-cycle command in progress (= !cmd_ready)
//   done                one-cycle pulse: final write of a command is visible
//   err                 one-cycle pulse: accepted command had a bad address
//   dbg_state           current FSM state
module tile_map_writer #(
   parameter int COLS   = 20,
   parameter int ROWS   = 20,
   parameter int CODE_W = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [4:0]        cmd_col,
   input  logic [4:0]        cmd_row,
   input  logic [CODE_W-1:0] cmd_code,
   input  logic [4:0]        rd_col,
   input  logic [4:0]        rd_row,
   output logic [CODE_W-1:0] rd_code,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;
   localparam logic [1:0] S_DROP  = 2'd3;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_DROP  = 2'd3;

   localparam logic [4:0] COLS_L   = 5'(COLS);
   localparam logic [4:0] ROWS_L   = 5'(ROWS);
   localparam logic [4:0] COLS_M1  = 5'(COLS - 1);
   localparam logic [4:0] ROWS_M1  = 5'(ROWS - 1);

   logic [CODE_W-1:0] mem [ROWS][COLS];
   logic [1:0]        state;
   logic [4:0]        idx;
   logic [4:0]        row_l;
   logic [CODE_W-1:0] code_l;

   logic col_ok, row_ok, rd_ok;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = ~cmd_ready;
   assign dbg_state = state;

   assign col_ok = (cmd_col < COLS_L);
   assign row_ok = (cmd_row < ROWS_L);
   assign rd_ok  = (rd_col < COLS_L) && (rd_row < ROWS_L);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               mem[r][c] <= '0;
         state   <= S_IDLE;
         idx     <= '0;
         row_l   <= '0;
         code_l  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         rd_code <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // Reads see pre-edge contents: a write on this same edge shows up
         // only on the following read.
         rd_code <= rd_ok ? mem[rd_row][rd_col] : '0;

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  row_l  <= cmd_row;
                  code_l <= cmd_code;
                  case (cmd_op)
                     OP_WRITE: begin
                        if (col_ok && row_ok) begin
                           mem[cmd_row][cmd_col] <= cmd_code;
                           done <= 1'b1;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_FILL: begin
                        if (row_ok) begin
                           idx   <= '0;
                           state <= S_FILL;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OP_CLEAR: begin
                        idx   <= '0;
                        state <= S_CLEAR;
                     end
                     default: begin
                        // Row drop walks down from the target row to row 0.
                        if (row_ok) begin
                           idx   <= cmd_row;
                           state <= S_DROP;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                  endcase
               end
            end

            S_FILL: begin
               mem[row_l][idx] <= code_l;
               if (idx == COLS_M1) begin
                  idx   <= '0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  idx <= idx + 5'd1;
               end
            end

            S_CLEAR: begin
               for (int c = 0; c < COLS; c++)
                  mem[idx][c] <= code_l;
               if (idx == ROWS_M1) begin
                  idx   <= '0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  idx <= idx + 5'd1;
               end
            end

            S_DROP: begin
               // Descending copy so each source row is read before it is
               // overwritten; row 0 is blanked last.
               if (idx == 5'd0) begin
                  for (int c = 0; c < COLS; c++)
                     mem[0][c] <= '0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  for (int c = 0; c < COLS; c++)
                     mem[idx][c] <= mem[idx - 5'd1][c];
                  idx <= idx - 5'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer
//   Directed self-checking bench for tile_map_writer. Inputs are driven 1 time
//   unit after the rising edge, outputs sampled at the same point. A plain
//   array model of the tile map holds the expected contents.
module tb_tile_map_writer;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_DROP  = 2'd3;

   logic       Clk;
   logic       Reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_col;
   logic [4:0] cmd_row;
   logic [1:0] cmd_code;
   logic [4:0] rd_col;
   logic [4:0] rd_row;
   logic [1:0] rd_code;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] dbg_state;

   int checks;
   int failures;

   logic [1:0] exp_mem [20][20];

   tile_map_writer #(.COLS(20), .ROWS(20), .CODE_W(2)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_col   (cmd_col),
      .cmd_row   (cmd_row),
      .cmd_code  (cmd_code),
      .rd_col    (rd_col),
      .rd_row    (rd_row),
      .rd_code   (rd_code),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // checking
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] col,
                        input logic [4:0] row, input logic [1:0] code);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_col   = col;
      cmd_row   = row;
      cmd_code  = code;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wr(input int col, input int row, input logic [1:0] code);
      issue(OP_WRITE, 5'(col), 5'(row), code);
      exp_mem[row][col] = code;
   endtask

   task automatic rd(input int col, input int row, output logic [1:0] code);
      rd_col = 5'(col);
      rd_row = 5'(row);
      tick();
      code = rd_code;
   endtask

   task automatic read_row(input int row, output logic [39:0] v);
      logic [1:0] c2;
      v = '0;
      for (int c = 0; c < 20; c++) begin
         rd(c, row, c2);
         v[c*2 +: 2] = c2;
      end
   endtask

   function automatic logic [39:0] model_row(input int row);
      logic [39:0] v;
      v = '0;
      for (int c = 0; c < 20; c++) v[c*2 +: 2] = exp_mem[row][c];
      return v;
   endfunction

   task automatic compare_row(input string tag, input int row);
      logic [39:0] got;
      read_row(row, got);
      check_eq($sformatf("%s_row%0d", tag, row), {24'd0, got}, {24'd0, model_row(row)});
   endtask

   task automatic compare_all(input string tag);
      for (int r = 0; r < 20; r++) compare_row(tag, r);
   endtask

   // Counts samples with busy high after the accepting edge; bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      logic [1:0]  c2;
      logic [39:0] rowv;
      int          n;

      checks    = 0;
      failures  = 0;
      Reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_col   = '0;
      cmd_row   = '0;
      cmd_code  = '0;
      rd_col    = '0;
      rd_row    = '0;
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 20; c++) exp_mem[r][c] = 2'd0;

      // ---- reset state ----
      tick(); tick();
      Reset = 1'b0;
      check_eq("rst_ready", 64'(cmd_ready), 64'd1);
      check_eq("rst_busy",  64'(busy),      64'd0);
      check_eq("rst_done",  64'(done),      64'd0);
      check_eq("rst_err",   64'(err),       64'd0);
      check_eq("rst_rd",    64'(rd_code),   64'd0);
      rd(0, 0, c2);   check_eq("rst_rd_0_0",   64'(c2), 64'd0);
      rd(19, 19, c2); check_eq("rst_rd_19_19", 64'(c2), 64'd0);

      // ---- back-to-back writes, same-edge read ----
      rd_col = 5'd3; rd_row = 5'd7;
      issue(OP_WRITE, 5'd3, 5'd7, 2'd2);
      exp_mem[7][3] = 2'd2;
      check_eq("w1_done",       64'(done),      64'd1);
      check_eq("w1_sameedge",   64'(rd_code),   64'd0);
      check_eq("w1_ready",      64'(cmd_ready), 64'd1);
      issue(OP_WRITE, 5'd19, 5'd19, 2'd3);
      exp_mem[19][19] = 2'd3;
      check_eq("w2_done",       64'(done),      64'd1);
      check_eq("w2_rd_3_7",     64'(rd_code),   64'd2);
      tick();
      check_eq("w2_done_drop",  64'(done),      64'd0);
      rd(3, 7, c2);   check_eq("w_rd_3_7",   64'(c2), 64'd2);
      rd(19, 19, c2); check_eq("w_rd_19_19", 64'(c2), 64'd3);
      rd(25, 3, c2);  check_eq("rd_oob",     64'(c2), 64'd0);

      // ---- fill row 5, with valid held high during busy ----
      wr(0, 4, 2'd3);
      wr(19, 6, 2'd2);
      cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_row = 5'd5; cmd_code = 2'd1;
      tick();
      check_eq("fill_ready_low", 64'(cmd_ready), 64'd0);
      cmd_op = OP_WRITE; cmd_col = 5'd0; cmd_row = 5'd0; cmd_code = 2'd3;
      count_busy(n);
      cmd_valid = 1'b0;
      check_eq("fill_busy_cycles", 64'(n),    64'd20);
      check_eq("fill_done",        64'(done), 64'd1);
      for (int c = 0; c < 20; c++) exp_mem[5][c] = 2'd1;
      compare_row("fill", 4);
      compare_row("fill", 5);
      compare_row("fill", 6);
      compare_row("fill", 0);

      // ---- row drop r=3 ----
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 20; c++) wr(c, r, 2'((c + r) % 4));
      issue(OP_DROP, 5'd0, 5'd3, 2'd3);
      check_eq("drop_done_early", 64'(done), 64'd0);
      count_busy(n);
      check_eq("drop_busy_cycles", 64'(n),    64'd4);
      check_eq("drop_done",        64'(done), 64'd1);
      for (int r = 3; r >= 1; r--)
         for (int c = 0; c < 20; c++) exp_mem[r][c] = exp_mem[r-1][c];
      for (int c = 0; c < 20; c++) exp_mem[0][c] = 2'd0;
      // hand value: old row 2 col 0 = (0+2)%4 = 2 now lives in row 3
      rd(0, 3, c2); check_eq("drop_rd_0_3", 64'(c2), 64'd2);
      compare_all("drop");

      // ---- row drop r=0 boundary ----
      wr(5, 0, 2'd2);
      wr(6, 1, 2'd3);
      issue(OP_DROP, 5'd0, 5'd0, 2'd1);
      count_busy(n);
      check_eq("drop0_busy_cycles", 64'(n),    64'd1);
      check_eq("drop0_done",        64'(done), 64'd1);
      for (int c = 0; c < 20; c++) exp_mem[0][c] = 2'd0;
      compare_row("drop0", 0);
      compare_row("drop0", 1);

      // ---- out-of-range commands ----
      issue(OP_WRITE, 5'd20, 5'd0, 2'd3);
      check_eq("oob_w_err",   64'(err),       64'd1);
      check_eq("oob_w_done",  64'(done),      64'd0);
      check_eq("oob_w_ready", 64'(cmd_ready), 64'd1);
      issue(OP_FILL, 5'd0, 5'd25, 2'd1);
      check_eq("oob_f_err",   64'(err),       64'd1);
      check_eq("oob_f_done",  64'(done),      64'd0);
      check_eq("oob_f_ready", 64'(cmd_ready), 64'd1);
      tick();
      check_eq("oob_err_drop", 64'(err),  64'd0);
      check_eq("oob_busy",     64'(busy), 64'd0);
      issue(OP_WRITE, 5'd0, 5'd20, 2'd3);
      check_eq("oob_wr_row_err", 64'(err), 64'd1);
      compare_all("oob");

      // ---- clear all, aborted by reset ----
      rd_col = 5'd0; rd_row = 5'd0;
      issue(OP_CLEAR, 5'd0, 5'd0, 2'd3);
      check_eq("clr_busy", 64'(busy), 64'd1);
      tick();  // E1: row 0 written
      tick();  // E2: read samples row 0
      check_eq("clr_rd_row0", 64'(rd_code), 64'd3);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq($sformatf("clr_nodone_%0d", i), 64'(done), 64'd0);
      end
      check_eq("clr_busy_before_rst", 64'(busy), 64'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check_eq("clr_rst_done",  64'(done),      64'd0);
      check_eq("clr_rst_ready", 64'(cmd_ready), 64'd1);
      check_eq("clr_rst_busy",  64'(busy),      64'd0);
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 20; c++) exp_mem[r][c] = 2'd0;
      compare_all("clr_rst");

      // ---- a full clear that completes ----
      issue(OP_CLEAR, 5'd0, 5'd0, 2'd2);
      count_busy(n);
      check_eq("clr_busy_cycles", 64'(n),    64'd20);
      check_eq("clr_done",        64'(done), 64'd1);
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 20; c++) exp_mem[r][c] = 2'd2;
      compare_row("clr", 0);
      compare_row("clr", 19);

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
